// File: rtl/clk_div_ctrl.sv
// Multi-channel programmable clock-enable scheduler: per-channel divide ratio,
// one-cycle enable pulse and near-50% square wave, with boundary-aligned ratio updates.
module clk_div_ctrl #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned CH_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              sync,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] running
);

    logic [DIV_W-1:0]  d_q   [NUM_CH];
    logic [DIV_W-1:0]  d_n   [NUM_CH];
    logic [DIV_W-1:0]  cnt_q [NUM_CH];
    logic [DIV_W-1:0]  cnt_n [NUM_CH];
    logic [DIV_W-1:0]  p_q   [NUM_CH];
    logic [DIV_W-1:0]  p_n   [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_n;
    logic [NUM_CH-1:0] ce_q, ce_n;
    logic [NUM_CH-1:0] clk_q, clk_n;
    logic [NUM_CH-1:0] run_q, run_n;
    logic [NUM_CH-1:0] take;
    logic              slot_busy;

    // Config accept: channel in range and its pending slot free
    always_comb begin
        slot_busy = 1'b0;
        take      = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (cfg_ch == CH_W'(i)) slot_busy = pend_q[i];
        end
        cfg_ready = (32'(cfg_ch) < NUM_CH) && !slot_busy;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            take[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
        end
    end

    // Per-channel next state; outputs are decoded from the next-state count
    always_comb begin
        pend_n = pend_q;
        ce_n   = '0;
        clk_n  = '0;
        run_n  = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            d_n[i]   = d_q[i];
            cnt_n[i] = cnt_q[i];
            p_n[i]   = p_q[i];
            if (d_q[i] == '0) begin
                cnt_n[i] = '0;
                if (take[i]) d_n[i] = cfg_div;
            end else if (sync || (cnt_q[i] == d_q[i] - DIV_W'(1))) begin
                // Period boundary or sync restart: new ratio lands here
                cnt_n[i] = '0;
                if (take[i]) begin
                    d_n[i] = cfg_div;
                end else if (pend_q[i]) begin
                    d_n[i]    = p_q[i];
                    pend_n[i] = 1'b0;
                end
            end else begin
                cnt_n[i] = cnt_q[i] + DIV_W'(1);
                if (take[i]) begin
                    p_n[i]    = cfg_div;
                    pend_n[i] = 1'b1;
                end
            end
            run_n[i] = (d_n[i] != '0);
            ce_n[i]  = (d_n[i] != '0) && (cnt_n[i] == d_n[i] - DIV_W'(1));
            // High for ceil(D/2) counts; D=1 keeps the square wave low
            clk_n[i] = (d_n[i] > DIV_W'(1)) &&
                       ({1'b0, cnt_n[i]} < (({1'b0, d_n[i]} + (DIV_W+1)'(1)) >> 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                d_q[i]   <= '0;
                cnt_q[i] <= '0;
                p_q[i]   <= '0;
            end
            pend_q <= '0;
            ce_q   <= '0;
            clk_q  <= '0;
            run_q  <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                d_q[i]   <= d_n[i];
                cnt_q[i] <= cnt_n[i];
                p_q[i]   <= p_n[i];
            end
            pend_q <= pend_n;
            ce_q   <= ce_n;
            clk_q  <= clk_n;
            run_q  <= run_n;
        end
    end

    assign ce      = ce_q;
    assign clk_out = clk_q;
    assign pending = pend_q;
    assign running = run_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Testbench for clk_div_ctrl: cycle model feeding an expected-output queue,
// plus directed waveform checks for the key scheduling scenarios.
module tb_clk_div_ctrl;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DIV_W  = 8;
    localparam int unsigned CH_W   = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              sync;
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] running;

    int checks = 0;
    int errors = 0;

    int md [NUM_CH];
    int mc [NUM_CH];
    int mp [NUM_CH];
    bit mpend [NUM_CH];

    typedef struct packed {
        logic [NUM_CH-1:0] ce;
        logic [NUM_CH-1:0] clk_out;
        logic [NUM_CH-1:0] pending;
        logic [NUM_CH-1:0] running;
    } obs_t;

    obs_t exp_q[$];

    always #5 clk = ~clk;

    clk_div_ctrl #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .CH_W(CH_W)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .sync(sync), .ce(ce),
        .clk_out(clk_out), .pending(pending), .running(running)
    );

    function automatic bit model_ready();
        if (int'(cfg_ch) >= int'(NUM_CH)) return 1'b0;
        return !mpend[int'(cfg_ch)];
    endfunction

    task automatic model_step(input bit rdy);
        obs_t e;
        if (reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                md[i] = 0; mc[i] = 0; mp[i] = 0; mpend[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                bit tk;
                tk = cfg_valid && rdy && (int'(cfg_ch) == i);
                if (md[i] == 0) begin
                    mc[i] = 0;
                    if (tk) md[i] = int'(cfg_div);
                end else if (sync || mc[i] == md[i] - 1) begin
                    mc[i] = 0;
                    if (tk) md[i] = int'(cfg_div);
                    else if (mpend[i]) begin md[i] = mp[i]; mpend[i] = 1'b0; end
                end else begin
                    mc[i]++;
                    if (tk) begin mp[i] = int'(cfg_div); mpend[i] = 1'b1; end
                end
            end
        end
        for (int i = 0; i < int'(NUM_CH); i++) begin
            e.ce[i]      = (md[i] >= 1) && (mc[i] == md[i] - 1);
            e.clk_out[i] = (md[i] >= 2) && (mc[i] < (md[i] + 1) / 2);
            e.pending[i] = mpend[i];
            e.running[i] = (md[i] != 0);
        end
        exp_q.push_back(e);
    endtask

    // One clock: check cfg_ready, advance model, compare registered outputs
    task automatic tick();
        bit   rdy;
        obs_t e;
        obs_t a;
        #1;
        rdy = model_ready();
        checks++;
        if (cfg_ready !== rdy) begin
            errors++;
            $display("FAIL cfg_ready ch=%0d: got %b expected %b", cfg_ch, cfg_ready, rdy);
        end
        model_step(rdy);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        a = {ce, clk_out, pending, running};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL scoreboard t=%0t: ce/clk/pend/run got %h_%h_%h_%h expected %h_%h_%h_%h",
                     $time, a.ce, a.clk_out, a.pending, a.running,
                     e.ce, e.clk_out, e.pending, e.running);
        end
    endtask

    task automatic cfg_write(input int ch, input int div);
        int n;
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = DIV_W'(div);
        n = 0;
        while (!model_ready() && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            checks++; errors++;
            $display("FAIL cfg_write_timeout ch=%0d: slot never drained", ch);
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int ch, input int cnt);
        int n;
        n = 0;
        while (mc[ch] != cnt && n < 40) begin tick(); n++; end
        if (n >= 40) begin
            checks++; errors++;
            $display("FAIL wait_cnt_timeout ch=%0d cnt=%0d", ch, cnt);
        end
    endtask

    task automatic wait_drain(input int ch);
        int n;
        n = 0;
        while (mpend[ch] && n < 40) begin tick(); n++; end
        if (n >= 40) begin
            checks++; errors++;
            $display("FAIL wait_drain_timeout ch=%0d", ch);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; sync = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({ce, clk_out, pending, running} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {ce, clk_out, pending, running});
        end
    endtask

    task automatic test_basic();
        bit ec[8];
        bit ee[8];
        ec = '{1, 1, 0, 0, 1, 1, 0, 0};
        ee = '{0, 0, 0, 1, 0, 0, 0, 1};
        cfg_write(0, 4);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            checks++;
            if ({clk_out[0], ce[0], pending[0]} !== {ec[k], ee[k], 1'b0}) begin
                errors++;
                $display("FAIL basic_d4 k=%0d: clk/ce/pend got %b%b%b expected %b%b0",
                         k, clk_out[0], ce[0], pending[0], ec[k], ee[k]);
            end
        end
    endtask

    task automatic test_switch();
        bit ec[8];
        bit ee[8];
        bit ep[8];
        ec = '{1, 0, 0, 1, 1, 0, 1, 1};
        ee = '{0, 0, 1, 0, 0, 1, 0, 0};
        ep = '{1, 1, 1, 0, 0, 0, 0, 0};
        wait_cnt(0, 0);
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd3;
        tick();
        cfg_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            checks++;
            if ({clk_out[0], ce[0], pending[0]} !== {ec[k], ee[k], ep[k]}) begin
                errors++;
                $display("FAIL switch_4to3 k=%0d: clk/ce/pend got %b%b%b expected %b%b%b",
                         k, clk_out[0], ce[0], pending[0], ec[k], ee[k], ep[k]);
            end
        end
    endtask

    task automatic test_stall();
        cfg_write(1, 6);
        tick();
        cfg_write(1, 2);
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd3;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_busy_slot: cfg_ready got %b expected 0", cfg_ready);
        end
        cfg_ch = 3'd2; cfg_div = 8'd7;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_other_ch: cfg_ready got %b expected 1", cfg_ready);
        end
        tick();
        cfg_write(1, 3);
    endtask

    task automatic test_sync();
        int first;
        int hits;
        cfg_write(0, 2);
        cfg_write(1, 5);
        wait_drain(0);
        wait_drain(1);
        tick(); tick(); tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        checks++;
        if ({clk_out[1:0], ce[1:0]} !== 4'b1100) begin
            errors++;
            $display("FAIL sync_align: clk_out[1:0]/ce[1:0] got %b%b expected 1100",
                     clk_out[1:0], ce[1:0]);
        end
        first = -1;
        hits  = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (ce[0] && ce[1]) begin
                hits++;
                if (first < 0) first = k;
            end
        end
        checks++;
        if (first != 9 || hits != 2) begin
            errors++;
            $display("FAIL sync_coincide: first=%0d hits=%0d expected first=9 hits=2", first, hits);
        end
    endtask

    task automatic test_stop();
        bit ee[5];
        bit er[5];
        ee = '{0, 1, 0, 0, 0};
        er = '{1, 1, 0, 0, 0};
        cfg_write(0, 4);
        wait_drain(0);
        wait_cnt(0, 1);
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd0;
        tick();
        cfg_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            checks++;
            if ({clk_out[0], ce[0], running[0], pending[0]} !== {1'b0, ee[k], er[k], er[k]}) begin
                errors++;
                $display("FAIL stop_d0 k=%0d: clk/ce/run/pend got %b%b%b%b expected 0%b%b%b",
                         k, clk_out[0], ce[0], running[0], pending[0], ee[k], er[k], er[k]);
            end
        end
        cfg_write(0, 1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            checks++;
            if ({clk_out[0], ce[0], running[0]} !== 3'b011) begin
                errors++;
                $display("FAIL d1_every_cycle k=%0d: clk/ce/run got %b%b%b expected 011",
                         k, clk_out[0], ce[0], running[0]);
            end
        end
    endtask

    task automatic test_reset_pending();
        cfg_write(3, 5);
        wait_drain(3);
        cfg_write(3, 2);
        checks++;
        if (pending[3] !== 1'b1) begin
            errors++;
            $display("FAIL ch3_pending_set: got %b expected 1", pending[3]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({ce, clk_out, pending, running} !== '0) begin
            errors++;
            $display("FAIL reset_mid_pending: got %h expected 0", {ce, clk_out, pending, running});
        end
        cfg_ch = 3'd3;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b expected 1", cfg_ready);
        end
        for (int c = int'(NUM_CH); c < 8; c++) begin
            cfg_ch = CH_W'(c);
            #1;
            checks++;
            if (cfg_ready !== 1'b0) begin
                errors++;
                $display("FAIL ch_out_of_range ch=%0d: cfg_ready got %b expected 0", c, cfg_ready);
            end
        end
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cfg_valid = ($urandom_range(0, 2) != 0);
            cfg_ch    = CH_W'($urandom_range(0, 5));
            cfg_div   = DIV_W'($urandom_range(0, 9));
            sync      = ($urandom_range(0, 24) == 0);
            tick();
        end
        cfg_valid = 1'b0;
        sync      = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_switch();
        test_stall();
        test_sync();
        test_stop();
        test_reset_pending();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
